// File: rtl/m72_irq_sched.sv
// m72_irq_sched
//   Interrupt scheduler sitting between the video timing generator and the
//   main V30 CPU. It latches vertical-blank start and raster-line match
//   events, masks and prioritises them, and raises one INT request. It then
//   answers the CPU's INTA handshake with an 8-bit vector and clears the
//   event that was serviced.
//
// Ports
//   CLK_32M  in   1   system clock
//   RESET_N  in   1   asynchronous active-low reset
//   CE_PIX   in   1   pixel enable, aligned with VE/HE updates
//   VE       in   9   vertical counter (offset +128)
//   HE       in   10  horizontal counter
//   VBLK     in   1   vertical blank level
//   WR       in   1   register write strobe
//   ADDR     in   2   register select: 0 raster_line, 1 mask, 2 vec_base, 3 OVR clear
//   DIN      in   16  write data
//   INTA     in   1   interrupt acknowledge (level)
//   INT      out  1   interrupt request
//   IV       out  8   interrupt vector, valid in ACK while INTA is high
//   PEND     out  2   pending events {raster, vblank}
//   OVR      out  2   sticky overrun flags {raster, vblank}

module m72_irq_sched #(
    parameter logic [9:0] RASTER_HPOS   = 10'd64,
    parameter logic [2:0] SPURIOUS_SLOT = 3'd7
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        CE_PIX,
    input  logic [8:0]  VE,
    input  logic [9:0]  HE,
    input  logic        VBLK,
    input  logic        WR,
    input  logic [1:0]  ADDR,
    input  logic [15:0] DIN,
    input  logic        INTA,
    output logic        INT,
    output logic [7:0]  IV,
    output logic [1:0]  PEND,
    output logic [1:0]  OVR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        vblk_q;
    logic        inta_q;
    logic        raster_done;
    logic [8:0]  raster_line;
    logic [1:0]  mask;
    logic [7:0]  vec_base;
    logic [1:0]  pend;
    logic [1:0]  ovr;
    logic [7:0]  iv;

    logic        vblank_evt;
    logic        raster_match;
    logic        raster_evt;
    logic [1:0]  evt;
    logic [1:0]  serviceable;
    logic        inta_rise;
    logic [1:0]  clr;
    logic        iv_load;
    logic [7:0]  iv_next;
    logic [1:0]  ovr_wclr;
    logic        unused_din;

    assign unused_din = ^DIN[15:9];

    // Event detection
    assign vblank_evt   = CE_PIX & VBLK & ~vblk_q;
    assign raster_match = CE_PIX && (VE == raster_line) && (HE == RASTER_HPOS);
    // raster_done blocks a second fire while HE lingers on the match column
    assign raster_evt   = raster_match & ~raster_done;
    assign evt          = {raster_evt, vblank_evt};

    assign serviceable  = pend & ~mask;
    assign inta_rise    = INTA & ~inta_q;
    assign ovr_wclr     = (WR && (ADDR == 2'd3)) ? DIN[1:0] : 2'b00;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            vblk_q      <= 1'b0;
            raster_done <= 1'b0;
        end else if (CE_PIX) begin
            vblk_q <= VBLK;
            if (raster_evt)
                raster_done <= 1'b1;
            else if (HE != RASTER_HPOS)
                raster_done <= 1'b0;
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N)
            inta_q <= 1'b0;
        else
            inta_q <= INTA;
    end

    // Register file
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            raster_line <= '0;
            mask        <= '1;
            vec_base    <= 8'h20;
        end else if (WR) begin
            case (ADDR)
                2'd0:    raster_line <= DIN[8:0];
                2'd1:    mask        <= DIN[1:0];
                2'd2:    vec_base    <= {DIN[7:3], 3'b000};
                default: ;
            endcase
        end
    end

    // Pending and overrun. A set in the same cycle as a service clear wins
    // and is not counted as an overrun, since the earlier event was consumed.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            pend <= '0;
            ovr  <= '0;
        end else begin
            pend <= evt | (pend & ~clr);
            ovr  <= (ovr & ~ovr_wclr) | (evt & pend & ~clr);
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            iv    <= '0;
        end else begin
            state <= state_next;
            if (iv_load)
                iv <= iv_next;
        end
    end

    always_comb begin
        state_next = state;
        clr        = 2'b00;
        iv_load    = 1'b0;
        iv_next    = iv;
        case (state)
            IDLE: begin
                if (serviceable != 2'b00)
                    state_next = REQ;
            end
            REQ: begin
                if (inta_rise) begin
                    iv_load    = 1'b1;
                    state_next = ACK;
                    if (serviceable[0]) begin
                        clr     = 2'b01;
                        iv_next = vec_base;
                    end else if (serviceable[1]) begin
                        clr     = 2'b10;
                        iv_next = vec_base | 8'h02;
                    end else begin
                        iv_next = vec_base | {5'b00000, SPURIOUS_SLOT};
                    end
                end else if (serviceable == 2'b00) begin
                    state_next = IDLE;
                end
            end
            ACK: begin
                if (!INTA)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign INT  = (state == REQ);
    assign IV   = iv;
    assign PEND = pend;
    assign OVR  = ovr;

endmodule

// File: doc/m72_irq_sched.md
Name: m72_irq_sched

Overview:
- Interrupt scheduler between the video timing generator and the main V30 CPU.
- Latches two timing events: vertical-blank start and programmable raster-line match.
- Masks and prioritises the pending events, then drives a single INT request to the CPU.
- Serves the CPU's INTA handshake by presenting an 8-bit vector and clearing the serviced event.

Parameters:
- RASTER_HPOS, 10'd64: HE value at which the raster-line compare fires (start of active line).
- SPURIOUS_SLOT, 3'd7: vector slot returned when INTA arrives with nothing serviceable.

Ports:
- CLK_32M  in  1  system clock; all logic is in this domain.
- RESET_N  in  1  asynchronous, active-low reset.
- CE_PIX  in  1  one-cycle pixel enable, aligned with timing counter updates.
- VE  in  9  vertical counter, offset form (+128).
- HE  in  10  horizontal counter.
- VBLK  in  1  vertical blank level.
- WR  in  1  one-cycle CPU register write strobe.
- ADDR  in  2  register select.
- DIN  in  16  write data.
- INTA  in  1  CPU interrupt acknowledge, level; may be held many cycles.
- INT  out  1  interrupt request to CPU.
- IV  out  8  vector, valid while INTA is high in the ACK state.
- PEND  out  2  pending bits {raster, vblank}, for debug and status reads.
- OVR  out  2  sticky overrun bits {raster, vblank}.

Behaviour:
- Reset: all outputs go to 0 immediately and asynchronously.
  - State IDLE.
  - raster_line = 9'd0, mask = 2'b11 (both events masked), vec_base = 8'h20.
  - VBLK edge register cleared.
- Register writes take effect on the cycle after WR:
  - ADDR 0: raster_line <= DIN[8:0].
  - ADDR 1: mask <= DIN[1:0]; bit 0 = vblank, bit 1 = raster; 1 = masked.
  - ADDR 2: vec_base <= {DIN[7:3], 3'b000}.
  - ADDR 3: OVR <= OVR & ~DIN[1:0].
- Events (each is a one-cycle set pulse):
  - vblank event: CE_PIX high and VBLK rising, i.e. VBLK=1 now and the sampled VBLK on the previous CE_PIX was 0.
  - raster event: CE_PIX high and VE == raster_line and HE == RASTER_HPOS. Fires at most once per line.
- Pending rules:
  - An event sets its PEND bit regardless of mask.
  - An event arriving while its bit is already set also sets the matching OVR bit.
  - If an event set and an INTA clear hit the same bit in the same cycle, set wins: the bit stays 1 and OVR is not set.
- Serviceable set: S = PEND & ~mask.
- FSM states: IDLE, REQ, ACK.
  - IDLE: INT = 0. If S != 0, go to REQ; INT rises on the next cycle.
  - REQ: INT = 1.
    - INTA rising with S != 0: pick the winner (vblank beats raster), clear its PEND bit, latch IV = vec_base | slot (vblank slot 0, raster slot 2), go to ACK.
    - INTA rising with S == 0 (event masked after the request): IV = vec_base | SPURIOUS_SLOT, go to ACK.
    - S drops to 0 without INTA: go to IDLE and deassert INT.
  - ACK: INT = 0 and IV held. On INTA low, go to IDLE.
- Latency:
  - Event to INT high: 2 cycles (pending register, then FSM).
  - INTA rise to valid IV: 1 cycle.
  - A second pending event re-raises INT 2 cycles after INTA falls (passes through IDLE).
- IV:
  - Holds its last value outside ACK.
  - Returns to 0 only on reset.
- Reset mid-handshake: returns to IDLE at once, pending events are lost, and INT falls asynchronously.
- raster_line >= 9'd412 (VE never reaches it): the raster event never fires. This is not an error.

Test Plan:
- Reset, then mask=0 and raster_line=9'd200. Run timing to VE=200, HE=64 → PEND[1]=1, INT high 2 cycles later. Pulse INTA → IV=8'h22, PEND[1]=0, INT low. INTA falls → IDLE.
- Raster and vblank pending together, mask=0. First INTA → IV=8'h20; second request follows → IV=8'h22, in that order.
- mask=2'b11 and VBLK rises → PEND[0]=1, INT stays 0. Write mask=0 → INT high 2 cycles later.
- Leave vblank unserviced across two frames → OVR[0]=1. Write ADDR 3 with DIN=1 → OVR[0]=0.
- In REQ, set mask=2'b11 the cycle before INTA rises → IV=8'h27 and PEND is unchanged.
- Assert RESET_N low during ACK → INT, IV, PEND and OVR all 0 immediately. After release, mask=2'b11 and vec_base=8'h20.
